// File: rtl/idle_timeout_pkg.sv
// Shared state encoding and default tuning for the idle timeout monitor.
package idle_timeout_pkg;

    localparam int CNT_W_DEF         = 8;
    localparam int WARN_TICKS_DEF    = 3;
    localparam int TIMEOUT_TICKS_DEF = 6;

    typedef enum logic [1:0] {
        ST_DISABLED  = 2'd0,
        ST_COUNTING  = 2'd1,
        ST_WARNING   = 2'd2,
        ST_TIMED_OUT = 2'd3
    } state_e;

endpackage

// File: rtl/slow_tick_sync.sv
// Brings the slow divided clock into the system domain and emits one-cycle
// ticks on its rising edges, once a genuinely sampled low has been seen.
module slow_tick_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_slow_clk_in,
    output logic o_tick_pulse
);

    logic       r_sync1;
    logic       r_sync2;
    logic [1:0] r_vld;
    logic       r_armed;
    logic       r_prev;
    logic       r_tick;

    // r_vld marks when r_sync2 holds a real input sample rather than its reset
    // value, so a line held high through reset cannot look like a rising edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_vld   <= 2'b00;
            r_armed <= 1'b0;
            r_prev  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_sync1 <= i_slow_clk_in;
            r_sync2 <= r_sync1;
            r_vld   <= {r_vld[0], 1'b1};
            r_prev  <= r_sync2;
            if (r_vld[1] && !r_sync2) begin
                r_armed <= 1'b1;
            end
            r_tick  <= r_armed & r_sync2 & ~r_prev;
        end
    end

    assign o_tick_pulse = r_tick;

endmodule

// File: rtl/idle_timeout_monitor.sv
// User-inactivity timer driven by slow clock ticks: warns, then latches a
// timeout until acknowledged. Define IDLE_AUTO_CLEAR_EN to let activity clear it.
//
// state        | meaning
// ST_DISABLED  | monitor off, counter held at zero
// ST_COUNTING  | counting idle ticks below the warning threshold
// ST_WARNING   | warning threshold reached, still counting
// ST_TIMED_OUT | timeout latched, counter frozen until acknowledged
module idle_timeout_monitor
    import idle_timeout_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter int WARN_TICKS    = WARN_TICKS_DEF,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_slow_clk_in,
    input  logic             i_enable,
    input  logic             i_activity,
    input  logic             i_timeout_ack,
    output logic             o_tick_pulse,
    output logic [CNT_W-1:0] o_idle_ticks,
    output logic             o_warn,
    output logic             o_timeout
);

    localparam logic [CNT_W-1:0] WARN_C    = CNT_W'(WARN_TICKS);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_idle_ticks;
    logic [CNT_W-1:0] w_idle_nxt;
    logic [CNT_W-1:0] w_idle_inc;
    logic             r_warn;
    logic             r_timeout;
    logic             w_tick;
    logic             w_leave_to;

    slow_tick_sync u_slow_tick_sync (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_slow_clk_in (i_slow_clk_in),
        .o_tick_pulse  (w_tick)
    );

`ifdef IDLE_AUTO_CLEAR_EN
    assign w_leave_to = i_timeout_ack | i_activity;
`else
    assign w_leave_to = i_timeout_ack;
`endif

    assign w_idle_inc = r_idle_ticks + ONE_C;

    always_comb begin
        w_state_nxt = r_state;
        w_idle_nxt  = r_idle_ticks;
        if (!i_enable) begin
            w_state_nxt = ST_DISABLED;
            w_idle_nxt  = '0;
        end else begin
            case (r_state)
                ST_DISABLED: begin
                    w_state_nxt = ST_COUNTING;
                    w_idle_nxt  = '0;
                end
                ST_COUNTING: begin
                    if (i_activity) begin
                        w_idle_nxt = '0;
                    end else if (w_tick) begin
                        w_idle_nxt = w_idle_inc;
                        if (w_idle_inc == WARN_C) begin
                            w_state_nxt = ST_WARNING;
                        end
                    end
                end
                ST_WARNING: begin
                    if (i_activity) begin
                        w_state_nxt = ST_COUNTING;
                        w_idle_nxt  = '0;
                    end else if (w_tick) begin
                        w_idle_nxt = w_idle_inc;
                        if (w_idle_inc == TIMEOUT_C) begin
                            w_state_nxt = ST_TIMED_OUT;
                        end
                    end
                end
                ST_TIMED_OUT: begin
                    if (w_leave_to) begin
                        w_state_nxt = ST_COUNTING;
                        w_idle_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_DISABLED;
                    w_idle_nxt  = '0;
                end
            endcase
        end
    end

    // Flags decode the next state so they line up with the counter update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_DISABLED;
            r_idle_ticks <= '0;
            r_warn       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idle_ticks <= w_idle_nxt;
            r_warn       <= (w_state_nxt == ST_WARNING);
            r_timeout    <= (w_state_nxt == ST_TIMED_OUT);
        end
    end

    assign o_tick_pulse = w_tick;
    assign o_idle_ticks = r_idle_ticks;
    assign o_warn       = r_warn;
    assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_idle_timeout_monitor.sv
// Directed bench for idle_timeout_monitor with WARN_TICKS=3, TIMEOUT_TICKS=5
// and a 40-cycle slow clock driven explicitly by the bench.
module tb_idle_timeout_monitor;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_slow_clk_in;
    logic       i_enable;
    logic       i_activity;
    logic       i_timeout_ack;
    logic       o_tick_pulse;
    logic [7:0] o_idle_ticks;
    logic       o_warn;
    logic       o_timeout;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] cur_idle;
    logic       cur_warn;
    logic       cur_to;
    logic       seen_tick;

    idle_timeout_monitor #(
        .CNT_W         (8),
        .WARN_TICKS    (3),
        .TIMEOUT_TICKS (5)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_slow_clk_in (i_slow_clk_in),
        .i_enable      (i_enable),
        .i_activity    (i_activity),
        .i_timeout_ack (i_timeout_ack),
        .o_tick_pulse  (o_tick_pulse),
        .o_idle_ticks  (o_idle_ticks),
        .o_warn        (o_warn),
        .o_timeout     (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] idle, input logic warn, input logic to);
        chk({tag, "_idle"}, 32'(o_idle_ticks), 32'(idle));
        chk({tag, "_warn"}, 32'(o_warn), 32'(warn));
        chk({tag, "_to"}, 32'(o_timeout), 32'(to));
        cur_idle = idle;
        cur_warn = warn;
        cur_to   = to;
    endtask

    // One 40-cycle slow period; the tick appears after the third edge and the
    // flags must still show the old state in that cycle.
    task automatic slow_period(input string tag, input logic act, input logic [7:0] idle,
                               input logic warn, input logic to);
        i_slow_clk_in = 1'b1;
        clk_n(3);
        chk({tag, "_tick"}, 32'(o_tick_pulse), 32'd1);
        chk({tag, "_pre_idle"}, 32'(o_idle_ticks), 32'(cur_idle));
        chk({tag, "_pre_warn"}, 32'(o_warn), 32'(cur_warn));
        chk({tag, "_pre_to"}, 32'(o_timeout), 32'(cur_to));
        i_activity = act;
        clk_n(1);
        i_activity = 1'b0;
        chk({tag, "_tick_w"}, 32'(o_tick_pulse), 32'd0);
        chk_state(tag, idle, warn, to);
        clk_n(16);
        i_slow_clk_in = 1'b0;
        clk_n(20);
    endtask

    task automatic ramp_to_timeout(input string tag);
        slow_period({tag, "1"}, 1'b0, 8'd1, 1'b0, 1'b0);
        slow_period({tag, "2"}, 1'b0, 8'd2, 1'b0, 1'b0);
        slow_period({tag, "3"}, 1'b0, 8'd3, 1'b1, 1'b0);
        slow_period({tag, "4"}, 1'b0, 8'd4, 1'b1, 1'b0);
        slow_period({tag, "5"}, 1'b0, 8'd5, 1'b0, 1'b1);
    endtask

    initial begin
        i_rst_n       = 1'b0;
        i_slow_clk_in = 1'b0;
        i_enable      = 1'b1;
        i_activity    = 1'b0;
        i_timeout_ack = 1'b0;
        cur_idle      = 8'd0;
        cur_warn      = 1'b0;
        cur_to        = 1'b0;
        clk_n(3);
        chk_state("rst", 8'd0, 1'b0, 1'b0);
        chk("rst_tick", 32'(o_tick_pulse), 32'd0);
        i_rst_n = 1'b1;
        clk_n(5);
        chk_state("armed", 8'd0, 1'b0, 1'b0);

        ramp_to_timeout("ramp");
        for (int i = 0; i < 3; i++) slow_period("hold", 1'b0, 8'd5, 1'b0, 1'b1);

        i_activity = 1'b1;
        clk_n(1);
        i_activity = 1'b0;
`ifdef IDLE_AUTO_CLEAR_EN
        chk_state("to_act", 8'd0, 1'b0, 1'b0);
        ramp_to_timeout("reramp");
`else
        chk_state("to_act", 8'd5, 1'b0, 1'b1);
`endif
        i_timeout_ack = 1'b1;
        clk_n(1);
        i_timeout_ack = 1'b0;
        chk_state("ack", 8'd0, 1'b0, 1'b0);

        slow_period("c1", 1'b0, 8'd1, 1'b0, 1'b0);
        slow_period("c2", 1'b0, 8'd2, 1'b0, 1'b0);
        slow_period("coll", 1'b1, 8'd0, 1'b0, 1'b0);
        slow_period("w1", 1'b0, 8'd1, 1'b0, 1'b0);
        slow_period("w2", 1'b0, 8'd2, 1'b0, 1'b0);
        slow_period("w3", 1'b0, 8'd3, 1'b1, 1'b0);

        i_timeout_ack = 1'b1;
        clk_n(1);
        i_timeout_ack = 1'b0;
        chk_state("ack_ign", 8'd3, 1'b1, 1'b0);
        i_activity = 1'b1;
        clk_n(1);
        i_activity = 1'b0;
        chk_state("warn_act", 8'd0, 1'b0, 1'b0);

        slow_period("e1", 1'b0, 8'd1, 1'b0, 1'b0);
        slow_period("e2", 1'b0, 8'd2, 1'b0, 1'b0);
        slow_period("e3", 1'b0, 8'd3, 1'b1, 1'b0);
        i_enable = 1'b0;
        clk_n(1);
        chk_state("dis", 8'd0, 1'b0, 1'b0);
        i_slow_clk_in = 1'b1;
        clk_n(3);
        chk("dis_tick", 32'(o_tick_pulse), 32'd1);
        clk_n(1);
        chk("dis_tick_w", 32'(o_tick_pulse), 32'd0);
        chk_state("dis_cnt", 8'd0, 1'b0, 1'b0);
        clk_n(16);
        i_slow_clk_in = 1'b0;
        clk_n(20);
        i_enable = 1'b1;
        clk_n(1);
        chk_state("reen", 8'd0, 1'b0, 1'b0);
        slow_period("en1", 1'b0, 8'd1, 1'b0, 1'b0);
        slow_period("en2", 1'b0, 8'd2, 1'b0, 1'b0);
        slow_period("en3", 1'b0, 8'd3, 1'b1, 1'b0);

        // Reset lands between clock edges; outputs must clear immediately.
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_state("arst", 8'd0, 1'b0, 1'b0);
        i_slow_clk_in = 1'b1;
        clk_n(2);
        i_rst_n   = 1'b1;
        seen_tick = 1'b0;
        for (int i = 0; i < 25; i++) begin
            clk_n(1);
            seen_tick = seen_tick | o_tick_pulse;
        end
        chk("hi_rst_no_tick", 32'(seen_tick), 32'd0);
        i_slow_clk_in = 1'b0;
        clk_n(20);
        chk_state("rearm", 8'd0, 1'b0, 1'b0);
        slow_period("rearm1", 1'b0, 8'd1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/idle_timeout_monitor.md
Name: idle_timeout_monitor

Overview:
Consumes the slow divided clock (0.1 Hz square wave, 10 s period) from the terminal's clock divider and turns it into a user-inactivity timer for the pseudo-terminal. It synchronizes the slow signal into the 100 MHz domain and rising-edge detects it into single-cycle ticks. It counts ticks since the last keystroke and raises a warning, then a latched timeout that the display/session logic must acknowledge.

Parameters:
CNT_W, 8, width of idle tick counter
WARN_TICKS, 3, ticks of inactivity before warn asserts (30 s at 10 s/tick)
TIMEOUT_TICKS, 6, ticks of inactivity before timeout asserts; legal range 1 <= WARN_TICKS < TIMEOUT_TICKS <= 2**CNT_W-1

Ports:
clk  in  1  100 MHz system clock
rst_n  in  1  asynchronous active-low reset
slow_clk_in  in  1  divided slow clock, asynchronous to clk in practice
enable  in  1  monitor enable; level
activity  in  1  one-cycle pulse per user event (keystroke/UART byte)
timeout_ack  in  1  one-cycle pulse from consumer clearing timeout
tick_pulse  out  1  one-cycle pulse per synchronized rising edge of slow_clk_in
idle_ticks  out  CNT_W  ticks elapsed since last activity
warn  out  1  high in WARNING state
timeout  out  1  high in TIMED_OUT state

Behaviour:
- Reset (async assert, sync deassert by system): sync flops=0, armed=0, state=DISABLED, idle_ticks=0, tick_pulse=0, warn=0, timeout=0.
- Tick path: 2-flop synchronizer, then edge register. tick_pulse=1 for exactly one clk when synchronized value goes 0->1. Latency: tick_pulse high on 3rd clk edge after slow_clk_in rises (setup met).
- Arming: no tick until at least one synchronized 0 has been sampled after reset. slow_clk_in held high through reset release produces no tick.
- tick_pulse operates in all states, including DISABLED.
- States: DISABLED, COUNTING, WARNING, TIMED_OUT (encoded in package).
- enable=0: any state -> DISABLED next cycle; idle_ticks=0; warn=timeout=0. Overrides everything else.
- DISABLED & enable=1 -> COUNTING, idle_ticks=0.
- COUNTING:
  - activity -> idle_ticks=0.
  - else tick -> idle_ticks+1; if new value == WARN_TICKS -> WARNING.
- WARNING:
  - activity -> COUNTING, idle_ticks=0.
  - else tick -> idle_ticks+1; if new value == TIMEOUT_TICKS -> TIMED_OUT.
- TIMED_OUT:
  - idle_ticks frozen at TIMEOUT_TICKS; ticks ignored.
  - activity ignored (see optional feature).
  - timeout_ack -> COUNTING, idle_ticks=0.
- warn and timeout are registered decodes of state: they rise the cycle after the triggering tick_pulse.
- Simultaneous events:
  - activity+tick same cycle: activity wins, idle_ticks=0.
  - timeout_ack outside TIMED_OUT: ignored.
  - ack+activity in TIMED_OUT: ack taken, idle_ticks=0.
- Counter never wraps: max reachable is TIMEOUT_TICKS.
- Reset mid-count: all state lost immediately; re-arming applies.

Optional Feature:
IDLE_AUTO_CLEAR_EN
- Defined: activity in TIMED_OUT is treated as timeout_ack (-> COUNTING, idle_ticks=0).
- Undefined: only timeout_ack leaves TIMED_OUT; activity there has no effect.

Decomposition:
- Package idle_timeout_pkg: state enum (DISABLED, COUNTING, WARNING, TIMED_OUT), default CNT_W, WARN_TICKS, TIMEOUT_TICKS constants.
- One sub-module slow_tick_sync: synchronizer + arm flag + rising-edge detect, output tick_pulse.
- The top level holds the FSM and counter.

Test Plan:
- Bench setup: WARN_TICKS=3, TIMEOUT_TICKS=5, slow_clk_in period 40 clk, enable=1, no activity.
- Basic ramp: warn rises 1 cycle after 3rd tick_pulse; timeout rises 1 cycle after 5th; idle_ticks holds 5 through 3 further ticks.
- Reset with slow_clk_in=1: release rst_n while slow_clk_in=1 -> no tick_pulse until slow_clk_in falls and rises again; each tick_pulse exactly 1 clk wide.
- Activity vs tick collision: idle_ticks=2, activity on same cycle as tick_pulse -> idle_ticks=0, state COUNTING. Activity in WARNING -> warn drops next cycle.
- Timeout acknowledge: TIMED_OUT, activity pulse -> timeout stays 1 (macro undefined) or drops (IDLE_AUTO_CLEAR_EN defined). timeout_ack -> timeout=0, idle_ticks=0 next cycle.
- Enable and reset overrides: enable=0 in WARNING -> warn=0, idle_ticks=0 next cycle, tick_pulse still toggles. Async rst_n pulse mid-count clears all outputs without a clk edge.
